// File: rtl/wb_xbar_rr_if.sv
// Flattened Wishbone classic bundle for `count` ports; port i occupies slice i of every vector.
interface wb_xbar_rr_if #(
  parameter int count      = 2,
  parameter int addr_width = 32,
  parameter int data_width = 32
);
  localparam int sel_width = data_width / 8;

  logic [count*addr_width-1:0] adr;
  logic [count*data_width-1:0] datwr;
  logic [count-1:0]            we;
  logic [count-1:0]            stb;
  logic [count-1:0]            cyc;
  logic [count*sel_width-1:0]  sel;
  logic [count*data_width-1:0] datrd;
  logic [count-1:0]            ack;

  modport master (output adr, datwr, we, stb, cyc, sel, input datrd, ack);
  modport slave  (input adr, datwr, we, stb, cyc, sel, output datrd, ack);
endinterface

// File: rtl/wb_xbar_rr.sv
// N-master x M-slave Wishbone classic crossbar: address decode, per-slave round-robin
// arbitration locked for the whole bus cycle, and a default responder for unmapped accesses.
module wb_xbar_rr #(
  parameter int master_count = 2,
  parameter int slave_count  = 2,
  parameter int addr_width   = 32,
  parameter int data_width   = 32,
  parameter logic [slave_count*addr_width-1:0] slave_base = '0,
  parameter logic [slave_count*addr_width-1:0] slave_mask = '1
) (
  input logic          clock,
  input logic          reset,
  wb_xbar_rr_if.slave  mst_bus,
  wb_xbar_rr_if.master slv_bus
);
  localparam int sel_width = data_width / 8;
  localparam int idx_width = (master_count > 1) ? $clog2(master_count) : 1;

  typedef enum logic {IDLE, BUSY} arb_state_e;

  arb_state_e              state_q     [slave_count];
  arb_state_e              state_d     [slave_count];
  logic [idx_width-1:0]    grant_idx_q [slave_count];
  logic [idx_width-1:0]    grant_idx_d [slave_count];
  logic [idx_width-1:0]    rr_ptr_q    [slave_count];
  logic [idx_width-1:0]    rr_ptr_d    [slave_count];
  logic [master_count-1:0] dflt_ack_q;
  logic [master_count-1:0] dflt_ack_d;

  logic [master_count-1:0] hit [slave_count];
  logic [master_count-1:0] req [slave_count];
  logic [master_count-1:0] claimed;
  logic [master_count-1:0] locked;
  logic [master_count-1:0] unmapped;

  // Lowest-index slave wins on overlap; an owning master is never re-decoded mid-cycle.
  always_comb begin
    claimed = '0;
    locked  = '0;
    for (int s = 0; s < slave_count; s++) begin
      hit[s] = '0;
      for (int m = 0; m < master_count; m++) begin
        if (!claimed[m] &&
            ((mst_bus.adr[m*addr_width +: addr_width] & slave_mask[s*addr_width +: addr_width])
             == slave_base[s*addr_width +: addr_width])) begin
          hit[s][m]  = 1'b1;
          claimed[m] = 1'b1;
        end
      end
      if (state_q[s] == BUSY) locked[grant_idx_q[s]] = 1'b1;
    end
    for (int s = 0; s < slave_count; s++) req[s] = mst_bus.cyc & hit[s] & ~locked;
    unmapped = ~claimed & ~locked;
  end

  always_comb begin
    for (int s = 0; s < slave_count; s++) begin
      state_d[s]     = state_q[s];
      grant_idx_d[s] = grant_idx_q[s];
      rr_ptr_d[s]    = rr_ptr_q[s];
      if (state_q[s] == IDLE || !mst_bus.cyc[grant_idx_q[s]]) begin
        if (state_q[s] == BUSY)
          rr_ptr_d[s] = idx_width'((int'(grant_idx_q[s]) + 1) % master_count);
        state_d[s] = IDLE;
        // Scan downwards so the requester closest to rr_ptr is the last (winning) assignment.
        for (int k = master_count - 1; k >= 0; k--) begin
          if (req[s][(int'(rr_ptr_d[s]) + k) % master_count]) begin
            state_d[s]     = BUSY;
            grant_idx_d[s] = idx_width'((int'(rr_ptr_d[s]) + k) % master_count);
          end
        end
      end
    end
  end

  // One-cycle ack per unmapped strobe; the ack clears itself so the next strobe is re-armed.
  assign dflt_ack_d = mst_bus.cyc & mst_bus.stb & unmapped & ~dflt_ack_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int s = 0; s < slave_count; s++) begin
        state_q[s]     <= IDLE;
        grant_idx_q[s] <= '0;
        rr_ptr_q[s]    <= '0;
      end
      dflt_ack_q <= '0;
    end else begin
      for (int s = 0; s < slave_count; s++) begin
        state_q[s]     <= state_d[s];
        grant_idx_q[s] <= grant_idx_d[s];
        rr_ptr_q[s]    <= rr_ptr_d[s];
      end
      dflt_ack_q <= dflt_ack_d;
    end
  end

  always_comb begin
    slv_bus.adr   = '0;
    slv_bus.datwr = '0;
    slv_bus.we    = '0;
    slv_bus.stb   = '0;
    slv_bus.cyc   = '0;
    slv_bus.sel   = '0;
    for (int s = 0; s < slave_count; s++) begin
      if (state_q[s] == BUSY) begin
        slv_bus.adr[s*addr_width +: addr_width] =
          mst_bus.adr[int'(grant_idx_q[s])*addr_width +: addr_width];
        slv_bus.datwr[s*data_width +: data_width] =
          mst_bus.datwr[int'(grant_idx_q[s])*data_width +: data_width];
        slv_bus.sel[s*sel_width +: sel_width] =
          mst_bus.sel[int'(grant_idx_q[s])*sel_width +: sel_width];
        slv_bus.we[s]  = mst_bus.we[grant_idx_q[s]];
        slv_bus.cyc[s] = mst_bus.cyc[grant_idx_q[s]];
        slv_bus.stb[s] = mst_bus.cyc[grant_idx_q[s]] & mst_bus.stb[grant_idx_q[s]];
      end
    end
  end

  always_comb begin
    mst_bus.ack   = dflt_ack_q & ~locked;
    mst_bus.datrd = '0;
    for (int s = 0; s < slave_count; s++) begin
      if (state_q[s] == BUSY) begin
        mst_bus.ack[grant_idx_q[s]] = slv_bus.ack[s];
        mst_bus.datrd[int'(grant_idx_q[s])*data_width +: data_width] =
          slv_bus.datrd[s*data_width +: data_width];
      end
    end
  end
endmodule
